// File: rtl/uart_cmd_rx_fsm_pkg.sv
// Shared constants for the UART-to-APB bridge: command byte codes, FSM encodings
// and default frame geometry used by both the RX assembler and the TX response path.
package uart_cmd_rx_fsm_pkg;

  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  localparam int DEF_ADDR_BYTES = 2;
  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_TIMEOUT    = 1000;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and flags
// expiry when the count reaches TIMEOUT-1.
module uart_rx_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_rx_fsm.sv
// Receive-side frame assembler: collects command, address and write-data bytes
// from the UART and presents the finished request to the APB master.
//
// Handshake: cmd_vld is high throughout ISSUE with cmd_wr/cmd_addr/cmd_wdata
// stable; the request transfers on any cycle where cmd_vld && cmd_rdy, after
// which cmd_vld drops. cmd_rdy is ignored outside ISSUE.
module uart_cmd_rx_fsm
  import uart_cmd_rx_fsm_pkg::*;
#(
  parameter int ADDR_BYTES = DEF_ADDR_BYTES,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_vld,
  input  logic                    rx_err,
  input  logic                    cmd_rdy,
  output logic                    cmd_vld,
  output logic                    cmd_wr,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    busy,
  output logic                    frm_err,
  output logic                    ovf,
  output logic [1:0]              state_dbg
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);

  logic [1:0]    state;
  logic [2:0]    byte_cnt;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          ovf_q;
  logic          in_frame;
  logic          expired;
  logic          abort;
  logic          is_cmd;

  assign in_frame = (state == ST_ADDR) || (state == ST_DATA);
  assign is_cmd   = (rx_data == CMD_RD) || (rx_data == CMD_WR);

  // A byte arriving on the expiry cycle rescues the frame, so expiry only aborts without rx_vld.
  assign abort = in_frame && ((rx_vld && rx_err) || (expired && !rx_vld));

  uart_rx_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_vld || !in_frame || expired),
    .en      (in_frame),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_vld && !rx_err && is_cmd) begin
            state    <= ST_ADDR;
            wr_q     <= (rx_data == CMD_WR);
            byte_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
          end
        end
        ST_ADDR: begin
          if (rx_vld) begin
            addr_q <= (addr_q << 8) | AW'(rx_data);
            if (byte_cnt == ADDR_LAST) begin
              byte_cnt <= '0;
              state    <= wr_q ? ST_DATA : ST_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        ST_DATA: begin
          if (rx_vld) begin
            wdata_q <= (wdata_q << 8) | DW'(rx_data);
            if (byte_cnt == DATA_LAST) begin
              byte_cnt <= '0;
              state    <= ST_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        default: begin
          // Bytes cannot be buffered while a request is pending; flag and drop.
          if (rx_vld) ovf_q <= 1'b1;
          if (cmd_rdy) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_vld   = (state == ST_ISSUE);
  assign cmd_wr    = wr_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;
  assign busy      = (state != ST_IDLE);
  assign frm_err   = abort;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule
